// File: rtl/iiitb_r2_4bit_div.sv
// Sequential radix-2 restoring divider: one-cycle load, N shift/subtract cycles, one sign-fix cycle.
// Define IIITB_DIV_SIGNED_EN for two's-complement operation; leave it undefined for unsigned.
module iiitb_r2_4bit_div #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [N-1:0] M,
  input  logic [N-1:0] Q,
  output logic [N-1:0] QUO,
  output logic [N-1:0] REM,
  output logic         busy,
  output logic         done,
  output logic         dbz,
  output logic         ovf,
  output logic [1:0]   dbg_state
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_N   = CW'(N);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [N-1:0]  ONE     = N'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} state_e;

  state_e        state_q, state_d;
  logic [N:0]    a_q, a_d;
  logic [N-1:0]  d_q, d_d;
  logic [N-1:0]  v_q, v_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;

  logic [N-1:0]  q_mag, m_mag;
  logic [N+1:0]  a_sh;
  logic [N:0]    diff;
  logic          ge;
  logic [N-1:0]  quo_fix, rem_fix;
  logic          ovf_fix;

`ifdef IIITB_DIV_SIGNED_EN
  logic sq_q, sq_d, sm_q, sm_d;

  // The most-negative input maps to 2^(N-1), which still fits unsigned in N bits.
  always_comb begin
    q_mag   = Q[N-1] ? (~Q + ONE) : Q;
    m_mag   = M[N-1] ? (~M + ONE) : M;
    quo_fix = (sq_q ^ sm_q) ? (~d_q + ONE) : d_q;
    rem_fix = sq_q ? (~a_q[N-1:0] + ONE) : a_q[N-1:0];
    // A positive quotient with its top bit set only arises from most-negative / -1.
    ovf_fix = ~(sq_q ^ sm_q) & d_q[N-1];
  end
`else
  always_comb begin
    q_mag   = Q;
    m_mag   = M;
    quo_fix = d_q;
    rem_fix = a_q[N-1:0];
    ovf_fix = 1'b0;
  end
`endif

  always_comb begin
    a_sh = {a_q, d_q[N-1]};
    ge   = (a_sh >= {2'b00, v_q});
    diff = a_sh[N:0] - {1'b0, v_q};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      d_q     <= '0;
      v_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef IIITB_DIV_SIGNED_EN
      sq_q    <= 1'b0;
      sm_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      d_q     <= d_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
`ifdef IIITB_DIV_SIGNED_EN
      sq_q    <= sq_d;
      sm_q    <= sm_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (cnt_q == CNT_ONE) state_d = FIX;
        FIX:     state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // Datapath: load overrides everything, so a mid-operation load aborts cleanly.
  always_comb begin
    a_d   = a_q;
    d_d   = d_q;
    v_d   = v_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
    ovf_d = ovf_q;
`ifdef IIITB_DIV_SIGNED_EN
    sq_d  = sq_q;
    sm_d  = sm_q;
`endif
    if (load) begin
      a_d   = '0;
      d_d   = q_mag;
      v_d   = m_mag;
      cnt_d = CNT_N;
      dbz_d = 1'b0;
      ovf_d = 1'b0;
`ifdef IIITB_DIV_SIGNED_EN
      sq_d  = Q[N-1];
      sm_d  = M[N-1];
`endif
    end else if (state_q == RUN) begin
      if (ge) begin
        a_d = diff;
        d_d = {d_q[N-2:0], 1'b1};
      end else begin
        a_d = a_sh[N:0];
        d_d = {d_q[N-2:0], 1'b0};
      end
      cnt_d = cnt_q - CNT_ONE;
    end else if (state_q == FIX) begin
      rem_d = rem_fix;
      if (v_q == '0) begin
        quo_d = '1;
        dbz_d = 1'b1;
        ovf_d = 1'b0;
      end else begin
        quo_d = quo_fix;
        dbz_d = 1'b0;
        ovf_d = ovf_fix;
      end
    end
  end

  always_comb begin
    busy      = (state_q == RUN) || (state_q == FIX);
    done      = (state_q == DONE);
    dbg_state = state_q;
    QUO       = quo_q;
    REM       = rem_q;
    dbz       = dbz_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_iiitb_r2_4bit_div.sv
// Self-checking bench for iiitb_r2_4bit_div; expectations follow IIITB_DIV_SIGNED_EN if defined.
module tb_iiitb_r2_4bit_div;
  localparam int N = 4;
  localparam int W = 2 * N + 2;

  logic         clk;
  logic         reset_n;
  logic         load;
  logic [N-1:0] M, Q;
  logic [N-1:0] QUO, REM;
  logic         busy, done, dbz, ovf;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  iiitb_r2_4bit_div #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .M(M), .Q(Q),
    .QUO(QUO), .REM(REM), .busy(busy), .done(done), .dbz(dbz), .ovf(ovf),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {quotient, remainder, dbz, ovf}, computed with plain integer arithmetic.
  function automatic logic [W-1:0] model(input logic [N-1:0] q, input logic [N-1:0] m);
    int qi, mi, qo, ro;
    logic [N-1:0] qv, rv;
    logic z, o;
    z = (m == '0);
    o = 1'b0;
`ifdef IIITB_DIV_SIGNED_EN
    qi = int'($signed(q));
    mi = int'($signed(m));
`else
    qi = int'(q);
    mi = int'(m);
`endif
    if (z) begin
      qv = '1;
      rv = q;
    end else if (qi == -(2 ** (N - 1)) && mi == -1) begin
      qv = q;
      rv = '0;
      o  = 1'b1;
    end else begin
      qo = qi / mi;
      ro = qi % mi;
      qv = qo[N-1:0];
      rv = ro[N-1:0];
    end
    return {qv, rv, z, o};
  endfunction

  // Called at a negedge: presents operands for the next posedge, ends on the following negedge.
  task automatic launch(input logic [N-1:0] q, input logic [N-1:0] m, input logic [W-1:0] exp, input bit push);
    Q    = q;
    M    = m;
    load = 1'b1;
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_done(input string name, input bit check_lat);
    int cyc = 0;
    int busy_n = 0;
    bit both = 1'b0;
    logic [W-1:0] exp;
    while (!done && cyc < 20) begin
      if (busy) busy_n++;
      @(negedge clk);
      cyc++;
      if (busy && done) both = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: no done after %0d cycles, required 5", name, cyc);
      return;
    end
    if (check_lat) begin
      checks++;
      if (cyc !== N + 1) begin
        errors++;
        $display("FAIL %s latency: got %0d, required %0d", name, cyc, N + 1);
      end
      checks++;
      if (busy_n !== N + 1) begin
        errors++;
        $display("FAIL %s busy_cycles: got %0d, required %0d", name, busy_n, N + 1);
      end
    end
    checks++;
    if (both) begin
      errors++;
      $display("FAIL %s busy_done_overlap: got 1, required 0", name);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard_empty: got 0 entries, required 1", name);
      return;
    end
    exp = exp_q.pop_front();
    checks++;
    if ({QUO, REM, dbz, ovf} !== exp) begin
      errors++;
      $display("FAIL %s result: got quo=%h rem=%h dbz=%b ovf=%b, required quo=%h rem=%h dbz=%b ovf=%b",
               name, QUO, REM, dbz, ovf, exp[W-1 -: N], exp[N+1 -: N], exp[1], exp[0]);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    load    = 1'b0;
    Q       = '0;
    M       = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({QUO, REM, busy, done, dbz, ovf, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_state: got quo=%h rem=%h busy=%b done=%b dbz=%b ovf=%b st=%0d, required all 0",
               QUO, REM, busy, done, dbz, ovf, dbg_state);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit stable = 1'b1;
    launch(4'd7, 4'd2, {4'd3, 4'd1, 1'b0, 1'b0}, 1'b1);
    wait_done("basic_7_2", 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (QUO !== 4'd3 || REM !== 4'd1 || done !== 1'b1 || busy !== 1'b0 || dbz !== 1'b0 || ovf !== 1'b0)
        stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL hold_after_done: got quo=%h rem=%h done=%b busy=%b, required quo=3 rem=1 done=1 busy=0",
               QUO, REM, done, busy);
    end
  endtask

  task automatic test_vectors();
    @(negedge clk);
`ifdef IIITB_DIV_SIGNED_EN
    launch(4'b1001, 4'd2, {4'b1101, 4'b1111, 1'b0, 1'b0}, 1'b1);
    wait_done("neg7_div_2", 1'b1);
    launch(4'b1000, 4'b1111, {4'b1000, 4'b0000, 1'b0, 1'b1}, 1'b1);
    wait_done("ovf_neg8_div_neg1", 1'b1);
    launch(4'b1000, 4'd3, {4'hE, 4'hE, 1'b0, 1'b0}, 1'b1);
    wait_done("neg8_div_3", 1'b1);
`else
    launch(4'b1001, 4'd2, {4'd4, 4'd1, 1'b0, 1'b0}, 1'b1);
    wait_done("u9_div_2", 1'b1);
    launch(4'b1000, 4'b1111, {4'd0, 4'd8, 1'b0, 1'b0}, 1'b1);
    wait_done("u8_div_15", 1'b1);
    launch(4'b1000, 4'd3, {4'd2, 4'd2, 1'b0, 1'b0}, 1'b1);
    wait_done("u8_div_3", 1'b1);
`endif
  endtask

  task automatic test_dbz();
    launch(4'd5, 4'd0, {4'hF, 4'd5, 1'b1, 1'b0}, 1'b1);
    wait_done("dbz_5_div_0", 1'b1);
`ifdef IIITB_DIV_SIGNED_EN
    launch(4'b1010, 4'd0, {4'hF, 4'b1010, 1'b1, 1'b0}, 1'b1);
`else
    launch(4'd10, 4'd0, {4'hF, 4'd10, 1'b1, 1'b0}, 1'b1);
`endif
    wait_done("dbz_10_div_0", 1'b1);
  endtask

  task automatic test_abort();
    launch(4'd7, 4'd2, '0, 1'b0);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_running: got done=%b busy=%b, required done=0 busy=1", done, busy);
    end
    launch(4'd6, 4'd3, {4'd2, 4'd0, 1'b0, 1'b0}, 1'b1);
    wait_done("abort_reload_6_3", 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] q, m;
    for (int i = 0; i < 24; i++) begin
      q = N'($urandom_range(0, 2 ** N - 1));
      m = N'($urandom_range(0, 2 ** N - 1));
      launch(q, m, model(q, m), 1'b1);
      wait_done($sformatf("rand_%0d_q%h_m%h", i, q, m), 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    bit quiet = 1'b1;
    launch(4'd7, 4'd3, '0, 1'b0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({QUO, REM, busy, done, dbz, ovf, dbg_state} !== '0) begin
      errors++;
      $display("FAIL async_reset_mid_run: got quo=%h rem=%h busy=%b done=%b st=%0d, required all 0",
               QUO, REM, busy, done, dbg_state);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL idle_after_reset: got done=%b busy=%b st=%0d, required 0 0 0", done, busy, dbg_state);
    end
    launch(4'd7, 4'd3, {4'd2, 4'd1, 1'b0, 1'b0}, 1'b1);
    wait_done("after_reset_7_3", 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_dbz();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iiitb_r2_4bit_div.md
Name: iiitb_r2_4bit_div

Overview:
Sequential radix-2 signed divider; the inverse companion to the team's Booth multiplier. It takes a dividend Q and a divisor M with a one-cycle load, and performs one shift/subtract (restoring) iteration per clock on operand magnitudes. A sign-fix cycle then presents the quotient and remainder, truncated toward zero. Used as the division datapath next to the multiplier in the arithmetic unit.

Parameters:
N, 4, operand/result width in bits (N>=2); iteration counter width is clog2(N+1)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
load  input  1  capture M/Q and start a division; honoured in any state
M  input  N  divisor
Q  input  N  dividend
QUO  output  N  quotient (registered)
REM  output  N  remainder (registered)
busy  output  1  high in RUN and FIX
done  output  1  high in DONE; held until next load or reset
dbz  output  1  divide-by-zero flag, valid with done
ovf  output  1  signed overflow flag (most-negative / -1), valid with done

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; QUO, REM, busy, done, dbz, ovf all 0; internal regs 0.
- States: IDLE, RUN, FIX, DONE. IDLE/DONE -> RUN on load. RUN -> FIX when count reaches 0. FIX -> DONE unconditionally. DONE holds.
- load=1 at edge k, any state: capture |Q| into dividend shift reg D, |M| into divisor reg V, signs sQ=Q[N-1] and sM=M[N-1]. Clear partial remainder A (N+1 bits). Set count=N, state=RUN. Clear done/dbz/ovf. QUO/REM keep old values until FIX.
- Load mid-operation aborts the current division and restarts with the new operands. No result is produced for the aborted division.
- RUN, each edge:
  - {A,D} shifts left by 1; T = A_shifted - {0,V}.
  - If T >= 0: A=T and D[0]=1; else A unchanged and D[0]=0.
  - count decrements.
- Magnitude of the most-negative input is 2^(N-1), held unsigned in N bits. No loss.
- FIX edge (edge k+N+1):
  - QUO = (sQ^sM) ? -D : D
  - REM = sQ ? -A[N-1:0] : A[N-1:0]
  - Results are truncated to N bits (two's complement).
  - done=1; state=DONE.
- Latency: load edge to done high = N+1 clocks (5 for N=4). It is fixed regardless of operands.
- Divide by zero (captured M==0): iterations still run, so latency is unchanged. At FIX: QUO=all ones, REM=Q as captured, dbz=1, ovf=0.
- Overflow: Q=most-negative and M=-1 gives QUO=most-negative (wraps), REM=0, ovf=1.
- busy = (state==RUN || state==FIX). done and busy are never both high.
- load and reset_n low together: reset wins.

Optional Feature:
IIITB_DIV_SIGNED_EN
- Defined: two's-complement signed operation as above. Magnitude conversion and sign fix are present; ovf is live.
- Undefined: unsigned operation. Magnitude and sign logic are removed, D=Q and V=M directly. The FIX cycle is still taken, so latency is identical. ovf is tied to 0. Divide-by-zero gives QUO=all ones, REM=Q.

Test Plan:
- Q=7, M=2, load one cycle: busy for 5 cycles, then done=1, QUO=3, REM=1, dbz=0, ovf=0. Outputs held stable for 10 further idle cycles.
- Signed: Q=4'b1001 (-7), M=2 -> QUO=4'b1101 (-3), REM=4'b1111 (-1). With macro undefined, same stimulus (9/2) -> QUO=4, REM=1.
- Q=5, M=0 -> after 5 cycles: dbz=1, QUO=4'hF, REM=5, ovf=0.
- Signed: Q=4'b1000, M=4'b1111 -> QUO=4'b1000, REM=0, ovf=1. Also Q=-8, M=3 -> QUO=-2 (4'hE), REM=-2 (4'hE), ovf=0.
- Load 7/2, then on the 2nd RUN cycle load 6/3 -> no done for 7/2. Done exactly 5 cycles after the second load edge, with QUO=2, REM=0.
- Drop reset_n mid-RUN, asynchronously between edges -> all outputs 0 immediately. After release, state is IDLE, with no done until the next load.
